// File: rtl/libiu.sv
// Shared reset-sequencer definitions: state encoding, default hold times and
// the per-state output decode used by rst_seq_ctrl.
package libiu;

  localparam int unsigned NTHREAD               = 32;
  localparam int unsigned RSTSEQ_LOCK_STABLE    = 16;
  localparam int unsigned RSTSEQ_DRAM_HOLD      = 32;
  localparam int unsigned RSTSEQ_CALIB_TIMEOUT  = 65536;
  localparam int unsigned RSTSEQ_CPU_HOLD       = NTHREAD + 20;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    DRAM_RST   = 3'd1,
    DRAM_CALIB = 3'd2,
    CPU_RST    = 3'd3,
    RUN        = 3'd4,
    ERR        = 3'd5
  } rstseq_state_type;

  typedef struct packed {
    logic cpu_rst;
    logic dram_rst;
    logic io_reset;
    logic ce_en;
    logic timeout_err;
  } rstseq_out_t;

  function automatic int unsigned rstseq_max4(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic rstseq_out_t rstseq_decode(input rstseq_state_type st);
    rstseq_out_t o;
    o = '{cpu_rst: 1'b1, dram_rst: 1'b1, io_reset: 1'b1, ce_en: 1'b0, timeout_err: 1'b0};
    unique case (st)
      WAIT_LOCK:  o = '{cpu_rst: 1'b1, dram_rst: 1'b1, io_reset: 1'b1, ce_en: 1'b0, timeout_err: 1'b0};
      DRAM_RST:   o = '{cpu_rst: 1'b1, dram_rst: 1'b1, io_reset: 1'b0, ce_en: 1'b0, timeout_err: 1'b0};
      DRAM_CALIB: o = '{cpu_rst: 1'b1, dram_rst: 1'b0, io_reset: 1'b0, ce_en: 1'b0, timeout_err: 1'b0};
      CPU_RST:    o = '{cpu_rst: 1'b1, dram_rst: 1'b0, io_reset: 1'b0, ce_en: 1'b1, timeout_err: 1'b0};
      RUN:        o = '{cpu_rst: 1'b0, dram_rst: 1'b0, io_reset: 1'b0, ce_en: 1'b1, timeout_err: 1'b0};
      ERR:        o = '{cpu_rst: 1'b1, dram_rst: 1'b1, io_reset: 1'b0, ce_en: 1'b0, timeout_err: 1'b1};
      default:    o = '{cpu_rst: 1'b1, dram_rst: 1'b1, io_reset: 1'b1, ce_en: 1'b0, timeout_err: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Platform-side bundle for the reset sequencer: status/request inputs and
// the reset/enable outputs. master = platform, slave = sequencer.
interface rst_seq_ctrl_if;
  logic       dcm_locked;
  logic       dram_calib_done;
  logic       cpurst_req;
  logic       dramrst_req;
  logic       cpu_rst;
  logic       dram_rst;
  logic       io_reset;
  logic       ce_en;
  logic       timeout_err;
  logic [2:0] seq_state;

  modport master (
    output dcm_locked, dram_calib_done, cpurst_req, dramrst_req,
    input  cpu_rst, dram_rst, io_reset, ce_en, timeout_err, seq_state
  );

  modport slave (
    input  dcm_locked, dram_calib_done, cpurst_req, dramrst_req,
    output cpu_rst, dram_rst, io_reset, ce_en, timeout_err, seq_state
  );
endinterface

// File: rtl/rstseq_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear; output is 0
// while in reset so downstream logic sees "not locked / not calibrated".
module rstseq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-up / warm reset sequencer: waits for stable clock lock, resets and
// calibrates DRAM, then releases the CPU; supports CPU-only and DRAM resets.
module rst_seq_ctrl
  import libiu::*;
#(
  parameter int unsigned LOCK_STABLE   = RSTSEQ_LOCK_STABLE,
  parameter int unsigned DRAM_HOLD     = RSTSEQ_DRAM_HOLD,
  parameter int unsigned CALIB_TIMEOUT = RSTSEQ_CALIB_TIMEOUT,
  parameter int unsigned CPU_HOLD      = RSTSEQ_CPU_HOLD
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       dcm_locked,
  input  logic       dram_calib_done,
  input  logic       cpurst_req,
  input  logic       dramrst_req,
  output logic       cpu_rst,
  output logic       dram_rst,
  output logic       io_reset,
  output logic       ce_en,
  output logic       timeout_err,
  output logic [2:0] seq_state
);

  localparam int unsigned CNT_MAX = rstseq_max4(LOCK_STABLE, DRAM_HOLD, CALIB_TIMEOUT, CPU_HOLD);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  // Each timed state lasts exactly N cycles: leave when the count entering
  // this edge is N-1 (count is 0 on the entry edge).
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] DRAM_LAST  = CNT_W'(DRAM_HOLD - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CPU_LAST   = CNT_W'(CPU_HOLD - 1);

  logic             lock_s;
  logic             calib_s;
  rstseq_state_type state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rstseq_out_t      out_q, out_d;

  rstseq_sync2 u_sync_lock (
    .clk   (clk),
    .rst_n (rstn),
    .d_i   (dcm_locked),
    .q_o   (lock_s)
  );

  rstseq_sync2 u_sync_calib (
    .clk   (clk),
    .rst_n (rstn),
    .d_i   (dram_calib_done),
    .q_o   (calib_s)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s && (cnt_q >= LOCK_LAST)) state_d = DRAM_RST;
      end
      DRAM_RST: begin
        if (cnt_q >= DRAM_LAST) state_d = DRAM_CALIB;
      end
      DRAM_CALIB: begin
        if (calib_s)                    state_d = CPU_RST;
        else if (cnt_q >= CALIB_LAST)   state_d = ERR;
      end
      CPU_RST: begin
        if (cnt_q >= CPU_LAST) state_d = RUN;
      end
      RUN: begin
        if (dramrst_req)     state_d = DRAM_RST;
        else if (cpurst_req) state_d = CPU_RST;
      end
      ERR: begin
        if (dramrst_req) state_d = DRAM_RST;
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Loss of lock overrides every other transition.
    if ((state_q != WAIT_LOCK) && !lock_s) state_d = WAIT_LOCK;
  end

  // Requests only act from RUN/ERR and always leave them, so every entry or
  // re-entry shows up as a state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                      cnt_d = '0;
    else if ((state_q == WAIT_LOCK) && !lock_s)  cnt_d = '0;
    else if (cnt_q != '1)                        cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    out_d = rstseq_decode(state_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      out_q   <= rstseq_decode(WAIT_LOCK);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign cpu_rst     = out_q.cpu_rst;
  assign dram_rst    = out_q.dram_rst;
  assign io_reset    = out_q.io_reset;
  assign ce_en       = out_q.ce_en;
  assign timeout_err = out_q.timeout_err;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected state changes
// with hand-computed cycle stamps; a negedge monitor checks each change.
module tb_rst_seq_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  rst_seq_ctrl_if bus ();

  rst_seq_ctrl #(
    .LOCK_STABLE   (4),
    .DRAM_HOLD     (8),
    .CALIB_TIMEOUT (64),
    .CPU_HOLD      (52)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .dcm_locked      (bus.dcm_locked),
    .dram_calib_done (bus.dram_calib_done),
    .cpurst_req      (bus.cpurst_req),
    .dramrst_req     (bus.dramrst_req),
    .cpu_rst         (bus.cpu_rst),
    .dram_rst        (bus.dram_rst),
    .io_reset        (bus.io_reset),
    .ce_en           (bus.ce_en),
    .timeout_err     (bus.timeout_err),
    .seq_state       (bus.seq_state)
  );

  typedef struct {
    int st;
    int cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_st;

  always @(posedge clk) cyc <= cyc + 1;

  // {cpu_rst, dram_rst, io_reset, ce_en, timeout_err} per state code
  function automatic int exp_outs(input int st);
    case (st)
      0:       return 5'b11100;
      1:       return 5'b11000;
      2:       return 5'b10000;
      3:       return 5'b10010;
      4:       return 5'b00010;
      5:       return 5'b11001;
      default: return 5'b11111;
    endcase
  endfunction

  function automatic int outs();
    return {27'd0, bus.cpu_rst, bus.dram_rst, bus.io_reset, bus.ce_en, bus.timeout_err};
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic push(input int st, input int c);
    exp_t e;
    e.st  = st;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d next_state=%0d next_cyc=%0d", sb_q.size(),
               sb_q[0].st, sb_q[0].cyc);
      sb_q.delete();
    end
    #2;
  endtask

  always @(negedge clk) begin
    if (mon_en && (bus.seq_state !== prev_st)) begin
      prev_st = bus.seq_state;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition actual_state=%0d expected=none cyc=%0d",
                 bus.seq_state, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("seq_state", int'(bus.seq_state), mon_e.st);
        chk("transition_cycle", cyc, mon_e.cyc);
        chk("outputs", outs(), exp_outs(mon_e.st));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    bus.dcm_locked      = 1'b0;
    bus.dram_calib_done = 1'b0;
    bus.cpurst_req      = 1'b0;
    bus.dramrst_req     = 1'b0;

    // Power-up reset, then lock, calibration 20 cycles after lock
    #1 rstn = 1'b0;
    tick(5);
    chk("reset_state", int'(bus.seq_state), 0);
    chk("reset_outputs", outs(), 5'b11100);
    rstn    = 1'b1;
    prev_st = bus.seq_state;
    mon_en  = 1'b1;
    tick(1);
    c = cyc;
    bus.dcm_locked = 1'b1;
    push(1, c + 6);
    push(2, c + 14);
    push(3, c + 23);
    push(4, c + 75);
    tick(20);
    bus.dram_calib_done = 1'b1;
    drain(100);

    // CPU-only reset from RUN
    c = cyc;
    bus.cpurst_req = 1'b1;
    push(3, c + 1);
    push(4, c + 53);
    tick(1);
    bus.cpurst_req = 1'b0;
    drain(80);

    // Both requests together: DRAM reset wins
    c = cyc;
    bus.cpurst_req  = 1'b1;
    bus.dramrst_req = 1'b1;
    push(1, c + 1);
    push(2, c + 9);
    push(3, c + 10);
    push(4, c + 62);
    tick(1);
    bus.cpurst_req  = 1'b0;
    bus.dramrst_req = 1'b0;
    drain(100);

    // Lock loss; cpurst_req lands on the edge the synchronized loss is seen
    c = cyc;
    bus.dcm_locked = 1'b0;
    push(0, c + 3);
    tick(2);
    bus.cpurst_req = 1'b1;
    tick(1);
    bus.cpurst_req = 1'b0;
    drain(20);

    // Relock with a one-cycle glitch at count 3 restarting the stable count
    tick(3);
    c = cyc;
    bus.dcm_locked = 1'b1;
    push(1, c + 10);
    push(2, c + 18);
    push(3, c + 19);
    push(4, c + 71);
    tick(3);
    bus.dcm_locked = 1'b0;
    tick(1);
    bus.dcm_locked = 1'b1;
    drain(100);

    // Calibration timeout into ERR
    c = cyc;
    bus.dram_calib_done = 1'b0;
    bus.dramrst_req     = 1'b1;
    push(1, c + 1);
    push(2, c + 9);
    push(5, c + 73);
    tick(1);
    bus.dramrst_req = 1'b0;
    drain(100);

    // Leave ERR with a held request (ignored once in DRAM_RST)
    tick(2);
    c = cyc;
    bus.dram_calib_done = 1'b1;
    bus.dramrst_req     = 1'b1;
    push(1, c + 1);
    push(2, c + 9);
    push(3, c + 10);
    tick(3);
    bus.dramrst_req = 1'b0;
    tick(37);

    // Reset mid CPU_RST (count 30), then full sequence again
    push(0, cyc);
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 5'b11100);
    tick(3);
    c = cyc;
    rstn = 1'b1;
    push(1, c + 6);
    push(2, c + 14);
    push(3, c + 15);
    push(4, c + 67);
    drain(100);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
